axil_regbank_msi: RTL

- AXI4-Lite register slave; sits directly downstream of axil_to_al as the replacement for the minimal AXI-Lite endpoint.
- Provides ID, scratch, free-running cycle-counter and interrupt-control registers.
- Drives the 7-series PCIe core MSI request handshake (cfg_interrupt / cfg_interrupt_rdy), so the host can trigger an MSI by writing a register and observe its completion.

---
 rtl/axil_regbank_pkg.sv | 52 +++++
 rtl/axil_regbank_msi_req_fsm.sv | 95 +++++++++
 rtl/axil_regbank_msi.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/axil_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_regbank_pkg
// Description : Shared constants for the AXI4-Lite register bank with MSI
//               request control: register byte offsets and word slots,
//               IRQ_CTRL / IRQ_STAT bit positions, AXI response codes and
//               the MSI request state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_regbank_pkg;

    // Register byte offsets
    localparam logic [7:0] c_OFFS_ID       = 8'h00;
    localparam logic [7:0] c_OFFS_SCRATCH0 = 8'h04;
    localparam logic [7:0] c_OFFS_SCRATCH1 = 8'h08;
    localparam logic [7:0] c_OFFS_SCRATCH2 = 8'h0C;
    localparam logic [7:0] c_OFFS_SCRATCH3 = 8'h10;
    localparam logic [7:0] c_OFFS_CYCLES   = 8'h14;
    localparam logic [7:0] c_OFFS_IRQ_CTRL = 8'h18;
    localparam logic [7:0] c_OFFS_IRQ_STAT = 8'h1C;

    // Word slots as decoded from address bits [4:2]
    localparam logic [2:0] c_SLOT_ID       = c_OFFS_ID[4:2];
    localparam logic [2:0] c_SLOT_SCRATCH0 = c_OFFS_SCRATCH0[4:2];
    localparam logic [2:0] c_SLOT_CYCLES   = c_OFFS_CYCLES[4:2];
    localparam logic [2:0] c_SLOT_IRQ_CTRL = c_OFFS_IRQ_CTRL[4:2];
    localparam logic [2:0] c_SLOT_IRQ_STAT = c_OFFS_IRQ_STAT[4:2];

    localparam int c_NUM_SCRATCH = 4;

    // IRQ_CTRL bits
    localparam int c_CTRL_EN_BIT   = 0;
    localparam int c_CTRL_TRIG_BIT = 1;
    localparam int c_CTRL_BUSY_BIT = 2;

    // IRQ_STAT bits
    localparam int c_STAT_DONE_BIT    = 0;
    localparam int c_STAT_DROPPED_BIT = 1;
    localparam int c_STAT_CNT_LSB     = 8;

    // AXI response codes
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    // MSI request state encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } msi_state_t;

endpackage : axil_regbank_pkg
`default_nettype wire

// File: rtl/axil_regbank_msi_req_fsm.sv
`default_nettype none
// ============================================================================
// Module      : msi_req_fsm
// Description : One-deep MSI request queue and cfg_interrupt handshake.
//               A qualified trigger sets the pending flag; the FSM consumes
//               it, raises cfg_interrupt and holds it until the core returns
//               cfg_interrupt_rdy. Reports DONE / DROPPED set pulses and a
//               wrapping count of completed requests.
// Ports       : clk, rst_n          - clock, async active-low reset
//               i_trig              - TRIG write with EN (new value) = 1
//               i_msienable         - MSI enabled by host
//               i_rdy               - core accepts request
//               o_cfg_interrupt     - MSI request (registered)
//               o_busy              - request in flight or pending
//               o_done_set          - one-cycle pulse on completion
//               o_dropped_set       - one-cycle pulse on a lost trigger
//               o_sent_cnt          - completed requests, wraps at 8 bits
// Revision    : 1.0 - initial release
// ============================================================================
module msi_req_fsm
    import axil_regbank_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_trig,
    input  logic       i_msienable,
    input  logic       i_rdy,
    output logic       o_cfg_interrupt,
    output logic       o_busy,
    output logic       o_done_set,
    output logic       o_dropped_set,
    output logic [7:0] o_sent_cnt
);

    msi_state_t r_state;
    logic       r_pending;
    logic       r_cfg_int;
    logic [7:0] r_sent_cnt;

    logic w_in_req;
    logic w_queue_full;
    logic w_accept;

    assign w_in_req     = (r_state == ST_REQ);
    // The single slot is only truly occupied while the FSM is busy; in IDLE
    // a pending flag is consumed this very cycle, making room for a trigger.
    assign w_queue_full = r_pending && w_in_req;
    assign w_accept     = i_trig && i_msienable && !w_queue_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pending  <= 1'b0;
            r_cfg_int  <= 1'b0;
            r_sent_cnt <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pending) begin
                        r_state   <= ST_REQ;
                        r_cfg_int <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // msienable is deliberately ignored here: once raised,
                    // the request is held until the core answers.
                    if (i_rdy) begin
                        r_state    <= ST_IDLE;
                        r_cfg_int  <= 1'b0;
                        r_sent_cnt <= r_sent_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cfg_int <= 1'b0;
                end
            endcase

            // A new trigger overrides the IDLE consume of the old flag.
            if (w_accept) begin
                r_pending <= 1'b1;
            end else if (!w_in_req && r_pending) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_cfg_interrupt = r_cfg_int;
    assign o_busy          = w_in_req || r_pending;
    assign o_done_set      = w_in_req && i_rdy;
    assign o_dropped_set   = i_trig && (!i_msienable || w_queue_full);
    assign o_sent_cnt      = r_sent_cnt;

endmodule : msi_req_fsm
`default_nettype wire

// File: rtl/axil_regbank_msi.sv
`default_nettype none
// ============================================================================
// Module      : axil_regbank_msi
// Description : AXI4-Lite register slave with ID, four scratch words, a
//               free-running cycle counter and MSI interrupt control for the
//               7-series PCIe core. Address bits [4:2] select one of eight
//               word slots; all other address bits are ignored.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               s_axi_aw* / s_axi_w* / s_axi_b* - AXI-Lite write channels
//               s_axi_ar* / s_axi_r*        - AXI-Lite read channels
//               cfg_interrupt / _rdy        - MSI request handshake
//               cfg_interrupt_assert, _di   - constant 0 (MSI vector 0)
//               cfg_interrupt_msienable     - MSI enabled by host
// Revision    : 1.0 - initial release
// ============================================================================
module axil_regbank_msi
    import axil_regbank_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'h7C0E_0001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  cfg_interrupt,
    input  logic                  cfg_interrupt_rdy,
    output logic                  cfg_interrupt_assert,
    output logic [7:0]            cfg_interrupt_di,
    input  logic                  cfg_interrupt_msienable
);

    logic        r_awready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_arready;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;
    logic [31:0] r_scratch [c_NUM_SCRATCH];
    logic [31:0] r_cycles;
    logic        r_irq_en;
    logic        r_done;
    logic        r_dropped;

    logic        w_wr_fire;
    logic        w_rd_fire;
    logic [2:0]  w_wr_slot;
    logic [2:0]  w_rd_slot;
    logic        w_ctrl_wr;
    logic        w_stat_wr;
    logic        w_trig;
    logic        w_busy;
    logic        w_done_set;
    logic        w_dropped_set;
    logic [7:0]  w_sent_cnt;
    logic [31:0] w_rd_mux;
    logic        w_unused_addr;

    assign w_wr_slot = s_axi_awaddr[4:2];
    assign w_rd_slot = s_axi_araddr[4:2];
    assign w_unused_addr = ^{s_axi_awaddr[ADDR_WIDTH-1:5], s_axi_awaddr[1:0],
                             s_axi_araddr[ADDR_WIDTH-1:5], s_axi_araddr[1:0]};

    // Readies are registered so they are 0 straight out of reset; the
    // handshake cycle is the one in which the registered ready is high.
    assign w_wr_fire = r_awready && s_axi_awvalid && s_axi_wvalid;
    assign w_rd_fire = r_arready && s_axi_arvalid;

    assign w_ctrl_wr = w_wr_fire && (w_wr_slot == c_SLOT_IRQ_CTRL) && s_axi_wstrb[0];
    assign w_stat_wr = w_wr_fire && (w_wr_slot == c_SLOT_IRQ_STAT) && s_axi_wstrb[0];

    // The EN value carried by this same write qualifies the trigger.
    assign w_trig = w_ctrl_wr && s_axi_wdata[c_CTRL_TRIG_BIT] && s_axi_wdata[c_CTRL_EN_BIT];

    // ------------------------------------------------------------------
    // Write channel and register updates
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_dropped <= 1'b0;
            for (int i = 0; i < c_NUM_SCRATCH; i++) begin
                r_scratch[i] <= 32'h0;
            end
        end else begin
            r_awready <= s_axi_awvalid && s_axi_wvalid && !r_bvalid && !r_awready;

            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= c_RESP_OKAY;
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end

            for (int i = 0; i < c_NUM_SCRATCH; i++) begin
                if (w_wr_fire && (w_wr_slot == c_SLOT_SCRATCH0 + 3'(i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_axi_wstrb[b]) begin
                            r_scratch[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                        end
                    end
                end
            end

            if (w_ctrl_wr) begin
                r_irq_en <= s_axi_wdata[c_CTRL_EN_BIT];
            end

            // Status bits: a set in the same cycle as a W1C wins.
            r_done    <= w_done_set ||
                         (r_done && !(w_stat_wr && s_axi_wdata[c_STAT_DONE_BIT]));
            r_dropped <= w_dropped_set ||
                         (r_dropped && !(w_stat_wr && s_axi_wdata[c_STAT_DROPPED_BIT]));
        end
    end

    // ------------------------------------------------------------------
    // Free-running cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= 32'h0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read mux: reflects register state before any same-cycle write
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = 32'h0;
        case (w_rd_slot)
            c_SLOT_ID:       w_rd_mux = ID_VALUE;
            c_SLOT_CYCLES:   w_rd_mux = r_cycles;
            c_SLOT_IRQ_CTRL: begin
                w_rd_mux[c_CTRL_EN_BIT]   = r_irq_en;
                w_rd_mux[c_CTRL_BUSY_BIT] = w_busy;
            end
            c_SLOT_IRQ_STAT: begin
                w_rd_mux[c_STAT_DONE_BIT]                   = r_done;
                w_rd_mux[c_STAT_DROPPED_BIT]                = r_dropped;
                w_rd_mux[c_STAT_CNT_LSB +: 8]               = w_sent_cnt;
            end
            default:         w_rd_mux = r_scratch[w_rd_slot - c_SLOT_SCRATCH0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_RESP_OKAY;
            r_rdata   <= 32'h0;
        end else begin
            r_arready <= s_axi_arvalid && !r_rvalid && !r_arready;

            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rresp  <= c_RESP_OKAY;
                r_rdata  <= w_rd_mux;
            end else if (r_rvalid && s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // MSI request engine
    // ------------------------------------------------------------------
    msi_req_fsm u_msi_req_fsm (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_trig          (w_trig),
        .i_msienable     (cfg_interrupt_msienable),
        .i_rdy           (cfg_interrupt_rdy),
        .o_cfg_interrupt (cfg_interrupt),
        .o_busy          (w_busy),
        .o_done_set      (w_done_set),
        .o_dropped_set   (w_dropped_set),
        .o_sent_cnt      (w_sent_cnt)
    );

    assign s_axi_awready        = r_awready;
    assign s_axi_wready         = r_awready;
    assign s_axi_bvalid         = r_bvalid;
    assign s_axi_bresp          = r_bresp;
    assign s_axi_arready        = r_arready;
    assign s_axi_rvalid         = r_rvalid;
    assign s_axi_rresp          = r_rresp;
    assign s_axi_rdata          = r_rdata;
    assign cfg_interrupt_assert = 1'b0;
    assign cfg_interrupt_di     = 8'h00;

endmodule : axil_regbank_msi
`default_nettype wire
